// File: rtl/adder34_accum_sequencer.sv
// adder34_accum_sequencer: multi-cycle accumulator that loads a 34-bit base and then adds a counted stream of 21-bit operands.
// It returns the 34-bit result and a sticky carry-out flag through a valid/ready handshake.

module customAdder34_13 (
    input  logic [33:0] a,
    input  logic [20:0] b,
    output logic [34:0] sum
);
    logic [13:0] lo;
    logic [13:0] mid0;
    logic [13:0] mid1;
    logic [8:0]  hi0;
    logic [8:0]  hi1;
    logic        mid_c;
    // Carry-select in 13-bit slices; upper slices precompute both carry-in cases
    assign lo    = {1'b0, a[12:0]} + {1'b0, b[12:0]};
    assign mid0  = {1'b0, a[25:13]} + {6'b0, b[20:13]};
    assign mid1  = mid0 + 14'd1;
    assign hi0   = {1'b0, a[33:26]};
    assign hi1   = hi0 + 9'd1;
    assign mid_c = lo[13] ? mid1[13] : mid0[13];
    assign sum   = {mid_c ? hi1 : hi0, lo[13] ? mid1[12:0] : mid0[12:0], lo[12:0]};
endmodule

module adder34_accum_sequencer #(
    parameter int A_W   = 34,
    parameter int B_W   = 21,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [A_W-1:0]   start_base,
    input  logic [CNT_W-1:0] start_count,
    output logic             busy,
    input  logic             op_valid,
    input  logic [B_W-1:0]   op_data,
    output logic             op_ready,
    output logic             res_valid,
    output logic [A_W-1:0]   res_data,
    output logic             res_ovf,
    input  logic             res_ready
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [A_W-1:0]   acc;
    logic [A_W-1:0]   acc_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic [A_W:0]     sum;

    customAdder34_13 adder (
        .a   (acc),
        .b   (op_data),
        .sum (sum)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        rem_nxt   = rem;
        case (state)
            IDLE: if (start) begin
                acc_nxt   = start_base;
                ovf_nxt   = 1'b0;
                rem_nxt   = start_count;
                state_nxt = start_count != '0 ? ACCUM : DONE;
            end
            ACCUM: if (op_valid) begin
                acc_nxt   = sum[A_W-1:0];
                ovf_nxt   = ovf | sum[A_W];
                rem_nxt   = rem - 1'b1;
                state_nxt = rem == CNT_W'(1) ? DONE : ACCUM;
            end
            DONE: state_nxt = res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            rem   <= rem_nxt;
        end
    end

    assign busy      = state != IDLE;
    assign op_ready  = state == ACCUM;
    assign res_valid = state == DONE;
    assign res_data  = acc;
    assign res_ovf   = ovf;
endmodule
